// File: rtl/velocity_ramp_pkg.sv
// Shared types for the velocity setpoint path: ramp FSM states and the
// signed velocity word used by the PI controller and diagnostics memory.
package velocity_ramp_pkg;

  localparam int VEL_WIDTH_DEFAULT = 16;

  typedef logic signed [VEL_WIDTH_DEFAULT-1:0] velocity_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAMP = 2'd1,
    STOP = 2'd2
  } ramp_state_t;

endpackage

// File: rtl/velocity_ramp_generator_tick_divider.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks (TICK_DIV 2..65535).
// Reused for filter and control-loop pulse generation.
module ramp_tick_divider
  import velocity_ramp_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [15:0] LAST_COUNT = 16'(TICK_DIV - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // next count: wrap at TICK_DIV-1
  always_comb begin
    count_d = count_q + 16'd1;
    if (count_q == LAST_COUNT) begin
      count_d = 16'd0;
    end else begin
      count_d = count_q + 16'd1;
    end
  end

  assign tick = (count_q == LAST_COUNT);

  // count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/velocity_ramp_generator.sv
// Slew-limited velocity setpoint generator feeding the BLDC PI loop.
// Optional: define VELOCITY_RAMP_DEADBAND_EN to snap small targets to zero.
module velocity_ramp_generator
  import velocity_ramp_pkg::*;
#(
  parameter int VEL_WIDTH  = VEL_WIDTH_DEFAULT,
  parameter int STEP_WIDTH = 12,
  parameter int TICK_DIV   = 1000
`ifdef VELOCITY_RAMP_DEADBAND_EN
  , parameter int DEADBAND = 8
`endif
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [VEL_WIDTH-1:0] target_velocity,
  input  logic                        target_valid,
  output logic                        target_ready,
  input  logic [STEP_WIDTH-1:0]       accel_step,
  input  logic                        stop_req,
  output logic signed [VEL_WIDTH-1:0] desired_velocity,
  output logic                        at_target,
  output logic                        ramp_active
);

  localparam logic signed [VEL_WIDTH-1:0] VEL_ZERO = {VEL_WIDTH{1'b0}};

  ramp_state_t                 state_q, state_d;
  logic signed [VEL_WIDTH-1:0] desired_q, desired_d;
  logic signed [VEL_WIDTH-1:0] target_q, target_d;
  logic                        at_target_q, at_target_d;
  logic                        ramp_active_q, ramp_active_d;

  logic                        tick_s;
  logic                        accept_s;
  logic signed [VEL_WIDTH-1:0] target_in_s;
  logic signed [VEL_WIDTH:0]   diff_s;
  logic [VEL_WIDTH:0]          diff_mag_s;
  logic [VEL_WIDTH-1:0]        step_w_s;
  logic [VEL_WIDTH:0]          step_ext_s;
  logic                        reached_s;
  logic signed [VEL_WIDTH-1:0] stepped_s;

  ramp_tick_divider #(.TICK_DIV(TICK_DIV)) u_tick_div (
    .clk   (clk),
    .reset (reset),
    .tick  (tick_s)
  );

  assign target_ready = !stop_req && (state_q != STOP);
  assign accept_s     = target_valid && target_ready;

`ifdef VELOCITY_RAMP_DEADBAND_EN
  logic signed [VEL_WIDTH:0] in_ext_s;
  logic [VEL_WIDTH:0]        in_mag_s;
  assign in_ext_s    = {target_velocity[VEL_WIDTH-1], target_velocity};
  assign in_mag_s    = in_ext_s[VEL_WIDTH] ? -in_ext_s : in_ext_s;
  assign target_in_s = (in_mag_s < (VEL_WIDTH+1)'(DEADBAND)) ? VEL_ZERO : target_velocity;
`else
  assign target_in_s = target_velocity;
`endif

  // One extra bit keeps the difference exact across the full signed range;
  // the stepped result itself never overshoots, so VEL_WIDTH bits suffice.
  assign diff_s     = {target_q[VEL_WIDTH-1], target_q} - {desired_q[VEL_WIDTH-1], desired_q};
  assign diff_mag_s = diff_s[VEL_WIDTH] ? -diff_s : diff_s;
  assign step_w_s   = {{(VEL_WIDTH-STEP_WIDTH){1'b0}}, accel_step};
  assign step_ext_s = {1'b0, step_w_s};
  assign reached_s  = (diff_mag_s <= step_ext_s);
  assign stepped_s  = reached_s      ? target_q :
                      diff_s[VEL_WIDTH] ? desired_q - $signed(step_w_s) :
                                          desired_q + $signed(step_w_s);

  // next-state, setpoint and status logic
  always_comb begin
    state_d   = state_q;
    desired_d = desired_q;
    target_d  = target_q;
    case (state_q)
      IDLE: begin
        if (stop_req) begin
          target_d = VEL_ZERO;
          state_d  = (desired_q != VEL_ZERO) ? STOP : IDLE;
        end else if (accept_s) begin
          target_d = target_in_s;
          state_d  = (target_in_s != desired_q) ? RAMP : IDLE;
        end else begin
          state_d = IDLE;
        end
      end
      RAMP: begin
        // The tick acts on the old target; a coincident accept or stop applies afterwards.
        if (tick_s) begin
          desired_d = stepped_s;
          state_d   = reached_s ? IDLE : RAMP;
        end else begin
          state_d = RAMP;
        end
        if (stop_req) begin
          target_d = VEL_ZERO;
          state_d  = (desired_d != VEL_ZERO) ? STOP : IDLE;
        end else if (accept_s) begin
          target_d = target_in_s;
          state_d  = (target_in_s != desired_d) ? RAMP : IDLE;
        end else begin
          target_d = target_q;
        end
      end
      STOP: begin
        if (tick_s) begin
          desired_d = stepped_s;
          state_d   = reached_s ? IDLE : STOP;
        end else begin
          state_d = STOP;
        end
      end
      default: begin
        state_d   = IDLE;
        desired_d = VEL_ZERO;
        target_d  = VEL_ZERO;
      end
    endcase
    at_target_d   = (desired_d == target_d);
    ramp_active_d = (state_d != IDLE);
  end

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      desired_q     <= VEL_ZERO;
      target_q      <= VEL_ZERO;
      at_target_q   <= 1'b1;
      ramp_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      desired_q     <= desired_d;
      target_q      <= target_d;
      at_target_q   <= at_target_d;
      ramp_active_q <= ramp_active_d;
    end
  end

  assign desired_velocity = desired_q;
  assign at_target        = at_target_q;
  assign ramp_active      = ramp_active_q;

endmodule

// File: doc/velocity_ramp_generator.md
Name: velocity_ramp_generator

Overview:
Upstream setpoint stage for the BLDC velocity controller. It produces the controller's signed 16-bit desired_velocity input.
- Accepts target velocities over a valid/ready handshake, e.g. from SPI register logic.
- Slews the output toward the target by at most accel_step counts per ramp tick, so the PI loop never sees a step command.
- Provides a stop request that ramps the output to zero, plus status flags for diagnostics.

Parameters:
VEL_WIDTH, 16, width of signed target/desired velocity
STEP_WIDTH, 12, width of unsigned acceleration step
TICK_DIV, 1000, clk cycles per ramp update; legal range 2..65535
DEADBAND, 8, magnitude below which targets snap to zero; used only with the optional feature

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
target_velocity  input  VEL_WIDTH  signed requested velocity
target_valid  input  1  target_velocity is valid
target_ready  output  1  block accepts a target this cycle
accel_step  input  STEP_WIDTH  unsigned max change per ramp tick, sampled on each tick
stop_req  input  1  level request to ramp to zero
desired_velocity  output  VEL_WIDTH  signed ramped setpoint, registered
at_target  output  1  desired_velocity == latched target, registered
ramp_active  output  1  state is RAMP or STOP, registered

Behaviour:
- Reset (reset low, asynchronous):
  - desired_velocity=0, latched target=0, state=IDLE, at_target=1, ramp_active=0, tick counter=0.
  - Reset mid-ramp discards all progress.
- Tick divider:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - ramp_tick asserts for one cycle when count==TICK_DIV-1.
  - The counter free-runs in every state; it is not restarted by new targets.
- target_ready: combinational = !stop_req && state!=STOP.
- Accept: accepted when target_valid && target_ready at a rising edge. The target is latched that edge; next state is RAMP if the new target != desired_velocity, else IDLE.
- States:
  - IDLE: desired==target. Accept -> RAMP or IDLE as above. stop_req -> STOP.
  - RAMP, on ramp_tick:
    - diff = target - desired, computed in VEL_WIDTH+1 bits, so no overflow at the -32768/32767 extremes.
    - If |diff| <= accel_step: desired=target, go to IDLE.
    - Else: desired += sign(diff)*accel_step.
    - A new accepted target retargets without changing desired (no jump); the next tick uses the new diff.
  - STOP: on entry, latched target is forced to 0. Ramps toward 0 with the same rule as RAMP. Reaching 0 -> IDLE, even if stop_req is still high. While stop_req stays high in IDLE, target_ready stays low.
- Priority when events coincide:
  - stop_req beats target_valid in the same cycle; that target is not accepted (ready low).
  - An accept coinciding with ramp_tick: the tick uses the old target, and the new target takes effect from the next tick.
- accel_step==0: desired holds; state stays RAMP/STOP indefinitely; no error.
- Output timing:
  - desired_velocity updates 1 clk after the ramp_tick edge.
  - at_target and ramp_active are registered and valid the same cycle as desired_velocity.
  - at_target = (desired==target) after the update. It drops in the cycle after a differing target is accepted.

Optional Feature:
VELOCITY_RAMP_DEADBAND_EN
- Defined: any accepted target with |target_velocity| < DEADBAND is latched as 0. Suppresses creep near zero, where the tick-time velocity lookup is coarse.
- Undefined: targets are latched verbatim; DEADBAND is unused.

Decomposition:
- Package velocity_ramp_pkg holds:
  - the ramp_state_t enum {IDLE, RAMP, STOP};
  - the VEL_WIDTH default constant;
  - the signed velocity typedef shared with the PI controller and diagnostics memory.
- One sub-module is natural: ramp_tick_divider (parameter TICK_DIV, ports clk, reset, tick). It is reusable for the filter/control-loop pulse generation.

Test Plan:
All scenarios use TICK_DIV=4.
- Reset release, no stimulus -> desired_velocity=0, at_target=1, ramp_active=0, target_ready=1 for 100 cycles.
- Target 100, accel_step 30 -> desired 30,60,90,100 on four successive ticks (4 clks apart); ramp_active falls and at_target rises with the 100 update.
- Target 32767, accel_step 4095, then target -32768 issued mid-ramp -> no overflow or wrap; desired reverses monotonically, ends exactly at -32768.
- In RAMP at desired 500, stop_req held high with simultaneous target_valid for 1000 -> target_ready=0, 1000 never latched; desired ramps to 0 in 4095-size steps, then IDLE.
- Target accepted on the same edge as ramp_tick with desired=0, old target 50, new target -50, step 10 -> that tick gives 10; the next tick gives 0, then -10.
- VELOCITY_RAMP_DEADBAND_EN defined, target 7, DEADBAND 8 -> latched 0, at_target stays 1. Undefined -> desired reaches 7.
